intr_ctrl: RTL and testbench



---
 rtl/intr_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_intr_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// -----------------------------------------------------------------------------
// intr_ctrl
//
// Interrupt controller for the pipelined RISC-V core. It picks the
// lowest-numbered enabled request and issues a one-cycle fetch redirect to
// that line's handler vector, saving the PC of the instruction in EX as the
// return address. When the handler's mret reaches EX, it issues a second
// redirect back to the saved PC. A status bit marks which fetch stream
// (handler or interrupted program) is in flight; a two-flop copy of that bit
// follows the stream down to EX. The hazard unit compares the two bits to
// decide what to flush or restore.
//
// Ports
//   i_clk          core clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_irq          level requests; each source holds its line until acked
//   i_irq_mask     per-line enable (1 = enabled)
//   i_global_en    global interrupt enable
//   i_ex_valid     EX holds a real instruction, not a bubble
//   i_ex_pc        PC of the EX instruction (the return address)
//   i_ex_mret      EX instruction is the return-from-interrupt
//   i_hazard_full  combined control/data hazard from the hazard unit
//   i_restore_pc   hazard unit is restoring the PC this cycle
//   o_intr_en      one-cycle fetch redirect strobe
//   o_intr_pc      redirect target, valid while o_intr_en is high
//   o_status_IF    fetch stream belongs to the handler
//   o_status_EX    EX stream belongs to the handler
//   o_epc          saved return PC
//   o_irq_ack      one-hot, one-cycle ack of the taken line
//   o_cause        index of the taken line
//   o_busy         controller is not idle
// -----------------------------------------------------------------------------
module intr_ctrl #(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_IRQ-1:0] i_irq,
    input  logic [N_IRQ-1:0] i_irq_mask,
    input  logic             i_global_en,
    input  logic             i_ex_valid,
    input  logic [31:0]      i_ex_pc,
    input  logic             i_ex_mret,
    input  logic             i_hazard_full,
    input  logic             i_restore_pc,
    output logic             o_intr_en,
    output logic [31:0]      o_intr_pc,
    output logic             o_status_IF,
    output logic             o_status_EX,
    output logic [31:0]      o_epc,
    output logic [N_IRQ-1:0] o_irq_ack,
    output logic [3:0]       o_cause,
    output logic             o_busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ENTER   = 2'd1;
    localparam logic [1:0] ST_HANDLER = 2'd2;
    localparam logic [1:0] ST_RETURN  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [31:0]      epc_q, epc_d;
    logic [3:0]       cause_q, cause_d;
    logic             status_if_q, status_if_d;
    logic             status_id_q;   // first flop of the IF->ID->EX shift
    logic             status_ex_q;   // second flop

    logic [N_IRQ-1:0] pend;
    logic             pend_any;
    logic [3:0]       sel_idx;
    logic             take;
    logic             ret_take;

    // -------------------------------------------------------------------------
    // Request selection
    // -------------------------------------------------------------------------
    assign pend     = i_irq & i_irq_mask;
    assign pend_any = |pend;

    // Scan from the top down so the lowest set index is the last writer.
    always_comb begin
        sel_idx = 4'd0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pend[i]) begin
                sel_idx = 4'(i);
            end
        end
    end

    // A take needs a real instruction in EX to supply the return PC, and no
    // hazard activity that could make that PC stale.
    assign take = pend_any && i_global_en && i_ex_valid &&
                  !i_hazard_full && !i_restore_pc;

    // Only an mret from the handler's own stream ends the handler; an mret
    // still draining from the interrupted program is not ours.
    assign ret_take = i_ex_mret && i_ex_valid && status_ex_q;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        epc_d       = epc_q;
        cause_d     = cause_q;
        status_if_d = status_if_q;

        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    state_d = ST_ENTER;
                    epc_d   = i_ex_pc;
                    cause_d = sel_idx;
                end
            end
            ST_ENTER: begin
                state_d     = ST_HANDLER;
                status_if_d = 1'b1;
            end
            ST_HANDLER: begin
                // No nesting: pending lines wait at the source.
                if (ret_take) begin
                    state_d = ST_RETURN;
                end
            end
            ST_RETURN: begin
                state_d     = ST_IDLE;
                status_if_d = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            epc_q       <= 32'd0;
            cause_q     <= 4'd0;
            status_if_q <= 1'b0;
            status_id_q <= 1'b0;
            status_ex_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            epc_q       <= epc_d;
            cause_q     <= cause_d;
            status_if_q <= status_if_d;
            status_id_q <= status_if_q;
            status_ex_q <= status_id_q;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (decoded from registered state only, so reset clears them
    // without waiting for a clock)
    // -------------------------------------------------------------------------
    always_comb begin
        o_intr_pc = 32'd0;
        case (state_q)
            ST_ENTER:  o_intr_pc = VEC_BASE + ({28'd0, cause_q} * VEC_STRIDE);
            ST_RETURN: o_intr_pc = epc_q;
            default:   o_intr_pc = 32'd0;
        endcase
    end

    always_comb begin
        o_irq_ack = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            o_irq_ack[i] = (state_q == ST_ENTER) && (cause_q == 4'(i));
        end
    end

    assign o_intr_en   = (state_q == ST_ENTER) || (state_q == ST_RETURN);
    assign o_status_IF = status_if_q;
    assign o_status_EX = status_ex_q;
    assign o_epc       = epc_q;
    assign o_cause     = cause_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;

    localparam int          N    = 4;
    localparam logic [31:0] VB   = 32'h0000_0100;
    localparam logic [31:0] VS   = 32'h0000_0010;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  irq, mask;
    logic          ge, exv, mret, hz, rp;
    logic [31:0]   ex_pc;
    logic          intr_en, sif, sex, busy;
    logic [31:0]   intr_pc, epc;
    logic [N-1:0]  ack;
    logic [3:0]    cause;

    int vec  = 0;
    int miss = 0;

    intr_ctrl #(.N_IRQ(N), .VEC_BASE(VB), .VEC_STRIDE(VS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_irq(irq), .i_irq_mask(mask),
        .i_global_en(ge), .i_ex_valid(exv), .i_ex_pc(ex_pc), .i_ex_mret(mret),
        .i_hazard_full(hz), .i_restore_pc(rp),
        .o_intr_en(intr_en), .o_intr_pc(intr_pc), .o_status_IF(sif),
        .o_status_EX(sex), .o_epc(epc), .o_irq_ack(ack), .o_cause(cause),
        .o_busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    localparam int M_IDLE = 0, M_ENTER = 1, M_HANDLER = 2, M_RETURN = 3;
    int          m_mode;
    logic [31:0] m_epc;
    int          m_cause;
    bit          m_hist[3];   // [0]=status_IF, [2]=status_EX (two cycles older)

    task automatic model_reset();
        m_mode = M_IDLE; m_epc = 0; m_cause = 0;
        for (int k = 0; k < 3; k++) m_hist[k] = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] p;
        bit           new_if;
        p = irq & mask;
        new_if = m_hist[0];
        case (m_mode)
            M_IDLE: if (p != 0 && ge && exv && !hz && !rp) begin
                m_mode = M_ENTER;
                m_epc  = ex_pc;
                for (int k = N - 1; k >= 0; k--) if (p[k]) m_cause = k;
            end
            M_ENTER:   begin m_mode = M_HANDLER; new_if = 1; end
            M_HANDLER: if (mret && exv && m_hist[2]) m_mode = M_RETURN;
            default:   begin m_mode = M_IDLE; new_if = 0; end
        endcase
        m_hist[2] = m_hist[1];
        m_hist[1] = m_hist[0];
        m_hist[0] = new_if;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- compare process ----------------
    initial begin
        forever begin
            @(negedge clk);
            begin
                logic [31:0] e_pc;
                logic [N-1:0] e_ack;
                bool_dummy();
                e_pc  = 0;
                e_ack = '0;
                if (m_mode == M_ENTER) begin
                    e_pc = VB + 32'(m_cause) * VS;
                    e_ack[m_cause] = 1'b1;
                end else if (m_mode == M_RETURN) begin
                    e_pc = m_epc;
                end
                check("intr_en", 32'(intr_en), 32'(m_mode == M_ENTER || m_mode == M_RETURN));
                check("intr_pc", intr_pc, e_pc);
                check("status_IF", 32'(sif), 32'(m_hist[0]));
                check("status_EX", 32'(sex), 32'(m_hist[2]));
                check("epc", epc, m_epc);
                check("irq_ack", 32'(ack), 32'(e_ack));
                check("cause", 32'(cause), 32'(m_cause));
                check("busy", 32'(busy), 32'(m_mode != M_IDLE));
            end
        end
    end

    task automatic bool_dummy();
    endtask

    // One clock: sample edge, advance model, land on the next falling edge.
    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        irq = '0; mask = '1; ge = 1; exv = 1; mret = 0; hz = 0; rp = 0; ex_pc = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0; model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        idle_inputs();
        rst_n = 0; model_reset();
        @(negedge clk);
        check("rst_intr_en", 32'(intr_en), 0);
        check("rst_epc", epc, 0);
        check("rst_busy", 32'(busy), 0);
        @(negedge clk);
        rst_n = 1;

        // Line 2, return address 0x40
        irq = 4'b0100; ex_pc = 32'h40;
        cyc();
        check("t1_en", 32'(intr_en), 1);
        check("t1_pc", intr_pc, 32'h120);
        check("t1_ack", 32'(ack), 32'h4);
        check("t1_epc", epc, 32'h40);
        check("t1_cause", 32'(cause), 2);
        irq = 0; ex_pc = 32'h44;
        cyc();
        check("t1_en_off", 32'(intr_en), 0);
        check("t1_sif", 32'(sif), 1);
        check("t1_sex_n2", 32'(sex), 0);
        cyc();
        check("t1_sex_n3", 32'(sex), 0);
        cyc();
        check("t1_sex_n4", 32'(sex), 1);

        // New request inside the handler is not taken
        irq = 4'b0001;
        cyc();
        check("nest_ack", 32'(ack), 0);
        check("nest_en", 32'(intr_en), 0);
        mret = 1; ex_pc = 32'h80;
        cyc();
        check("ret_en", 32'(intr_en), 1);
        check("ret_pc", intr_pc, 32'h40);
        mret = 0;
        cyc();
        check("ret_idle", 32'(busy), 0);
        check("ret_sif", 32'(sif), 0);
        cyc();
        check("pend_en", 32'(intr_en), 1);
        check("pend_ack", 32'(ack), 32'h1);
        check("pend_pc", intr_pc, 32'h100);
        check("pend_epc", epc, 32'h80);
        irq = 0;
        cyc();

        // Asynchronous reset while in the handler
        #2 rst_n = 0; model_reset();
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_sif", 32'(sif), 0);
        check("arst_epc", epc, 0);
        check("arst_cause", 32'(cause), 0);
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        cyc();
        check("arst_idle", 32'(busy), 0);

        // Priority under mask: only line 3 enabled
        irq = 4'b1010; mask = 4'b1000;
        cyc();
        check("mask_cause", 32'(cause), 3);
        check("mask_pc", intr_pc, 32'h130);
        irq = 0;
        do_reset();

        // Everything masked, then mret while idle
        irq = 4'b1111; mask = 4'b0000;
        for (int k = 0; k < 5; k++) begin cyc(); check("mask0_en", 32'(intr_en), 0); end
        irq = 0; mret = 1;
        for (int k = 0; k < 2; k++) begin cyc(); check("mret_idle", 32'(busy), 0); end
        mret = 0; mask = 4'b1111;

        // Hazard blocks the take for three cycles
        irq = 4'b0001; hz = 1;
        for (int k = 0; k < 3; k++) begin
            ex_pc = 32'h1000 + 32'(k) * 4;
            cyc();
            check("hz_block", 32'(intr_en), 0);
        end
        hz = 0; ex_pc = 32'h2000;
        cyc();
        check("hz_rel_en", 32'(intr_en), 1);
        check("hz_rel_epc", epc, 32'h2000);
        irq = 0;

        // mret before status_EX rises is ignored
        mret = 1;
        for (int k = 0; k < 3; k++) begin cyc(); check("early_mret", 32'(intr_en), 0); end
        mret = 0;
        check("early_sex", 32'(sex), 1);
        mret = 1;
        cyc();
        check("late_mret_pc", intr_pc, 32'h2000);
        mret = 0;
        do_reset();

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            if (m_mode == M_ENTER && $urandom_range(0, 3) != 0) irq[m_cause] = 1'b0;
            if ($urandom_range(0, 7) == 0) irq[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 15) == 0) irq[$urandom_range(0, N - 1)] = 1'b0;
            if ($urandom_range(0, 31) == 0) mask = N'($urandom);
            ge    = ($urandom_range(0, 9) != 0);
            exv   = ($urandom_range(0, 5) != 0);
            hz    = ($urandom_range(0, 3) == 0);
            rp    = ($urandom_range(0, 9) == 0);
            mret  = ($urandom_range(0, 4) == 0);
            ex_pc = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 499) == 0) begin
                #3 rst_n = 0; model_reset();
                @(negedge clk);
                rst_n = 1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
